// File: rtl/sap2_tstate_sequencer.sv
// SAP-2 run/halt/single-step controller and one-hot T-state ring generator.
// Adds memory wait-state stalls, a runaway-instruction watchdog and a retired-instruction counter.
module sap2_tstate_sequencer #(
  parameter int NUM_T = 18,
  parameter int CNT_W = 16
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic             iStepMode,
  input  logic             iStep,
  input  logic             iRingReset,
  input  logic             iHLT,
  input  logic             iMemWait,
  output logic [NUM_T-1:0] oTstate,
  output logic             oRunning,
  output logic             oHalted,
  output logic             oInstrDone,
  output logic             oTimeout,
  output logic [CNT_W-1:0] oInstrCount
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_HALT
  } state_t;

  localparam int TLAST = NUM_T - 1;
  localparam logic [NUM_T-1:0] T0 = {{(NUM_T-1){1'b0}}, 1'b1};

  state_t           r_state,   w_nextState;
  logic [NUM_T-1:0] r_tstate,  w_nextTstate;
  logic [CNT_W-1:0] r_count,   w_nextCount;
  logic             r_done,    w_nextDone;
  logic             r_timeout, w_nextTimeout;
  logic             r_running;
  logic             r_halted;
  logic             w_retire;

  always_comb begin
    w_nextState   = r_state;
    w_nextTstate  = r_tstate;
    w_nextCount   = r_count;
    w_nextDone    = 1'b0;
    w_nextTimeout = r_timeout;
    w_retire      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_nextTstate = '0;
        if (iStart) begin
          w_nextState  = ST_RUN;
          w_nextTstate = T0;
        end
      end
      ST_RUN: begin
        // Priority: stall, matrix end-of-instruction, HLT at T3, watchdog, advance.
        if (iMemWait) begin
          w_nextTstate = r_tstate;
        end else if (iRingReset) begin
          w_retire = 1'b1;
        end else if (iHLT && r_tstate[3]) begin
          w_nextState  = ST_HALT;
          w_nextTstate = '0;
          w_nextCount  = r_count + CNT_W'(1);
          w_nextDone   = 1'b1;
        end else if (r_tstate[TLAST]) begin
          w_nextTimeout = 1'b1;
          w_retire      = 1'b1;
        end else begin
          w_nextTstate = r_tstate << 1;
        end
      end
      ST_PAUSE: begin
        w_nextTstate = '0;
        if (iStep || !iStepMode) begin
          w_nextState  = ST_RUN;
          w_nextTstate = T0;
        end
      end
      ST_HALT: begin
        w_nextTstate = '0;
      end
      default: begin
        w_nextState  = ST_IDLE;
        w_nextTstate = '0;
      end
    endcase

    // A retiring instruction either restarts the ring or parks in PAUSE when stepping.
    if (w_retire) begin
      w_nextCount = r_count + CNT_W'(1);
      w_nextDone  = 1'b1;
      if (iStepMode) begin
        w_nextState  = ST_PAUSE;
        w_nextTstate = '0;
      end else begin
        w_nextTstate = T0;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state   <= ST_IDLE;
      r_tstate  <= '0;
      r_count   <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_running <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_tstate  <= w_nextTstate;
      r_count   <= w_nextCount;
      r_done    <= w_nextDone;
      r_timeout <= w_nextTimeout;
      r_running <= (w_nextState == ST_RUN);
      r_halted  <= (w_nextState == ST_HALT);
    end
  end

  assign oTstate     = r_tstate;
  assign oRunning    = r_running;
  assign oHalted     = r_halted;
  assign oInstrDone  = r_done;
  assign oTimeout    = r_timeout;
  assign oInstrCount = r_count;

endmodule

// File: tb/tb_sap2_tstate_sequencer.sv
// Directed self-checking bench for sap2_tstate_sequencer.
// Inputs change and outputs are checked on the falling edge; the DUT acts on the rising edge.
module tb_sap2_tstate_sequencer;

  localparam int NUM_T = 18;
  localparam int CNT_W = 16;

  logic             iClk = 1'b0;
  logic             iRst, iStart, iStepMode, iStep, iRingReset, iHLT, iMemWait;
  logic [NUM_T-1:0] oTstate;
  logic             oRunning, oHalted, oInstrDone, oTimeout;
  logic [CNT_W-1:0] oInstrCount;

  int total = 0;
  int bad   = 0;

  sap2_tstate_sequencer #(.NUM_T(NUM_T), .CNT_W(CNT_W)) dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iStart      (iStart),
    .iStepMode   (iStepMode),
    .iStep       (iStep),
    .iRingReset  (iRingReset),
    .iHLT        (iHLT),
    .iMemWait    (iMemWait),
    .oTstate     (oTstate),
    .oRunning    (oRunning),
    .oHalted     (oHalted),
    .oInstrDone  (oInstrDone),
    .oTimeout    (oTimeout),
    .oInstrCount (oInstrCount)
  );

  always #5 iClk = ~iClk;

  function automatic logic [NUM_T-1:0] tBit(input int k);
    logic [NUM_T-1:0] v;
    v = '0;
    if (k >= 0) v[k] = 1'b1;
    return v;
  endfunction

  // Drive one cycle of inputs, let a rising edge consume them, return on the falling edge.
  task automatic applyStimulus(input logic start, input logic stepMode, input logic step,
                               input logic ring, input logic hlt, input logic memWait,
                               input logic rst);
    iStart = start; iStepMode = stepMode; iStep = step;
    iRingReset = ring; iHLT = hlt; iMemWait = memWait; iRst = rst;
    @(posedge iClk);
    @(negedge iClk);
  endtask

  // tIdx = -1 means oTstate must be all-zero.
  task automatic checkOutput(input string tag, input int tIdx, input logic run,
                             input logic halt, input logic done, input logic tmo,
                             input logic [CNT_W-1:0] cnt);
    logic [NUM_T+CNT_W+3:0] obs, exp;
    obs = {oTstate, oRunning, oHalted, oInstrDone, oTimeout, oInstrCount};
    exp = {tBit(tIdx), run, halt, done, tmo, cnt};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed T=%h run=%b halt=%b done=%b tmo=%b cnt=%h expected T=%h run=%b halt=%b done=%b tmo=%b cnt=%h",
             tag, oTstate, oRunning, oHalted, oInstrDone, oTimeout, oInstrCount,
             tBit(tIdx), run, halt, done, tmo, cnt);
    end
  endtask

  initial begin
    // args: start, stepMode, step, ring, hlt, memWait, rst
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("reset", -1, 0, 0, 0, 0, 16'd0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("idle_ignores_memwait", -1, 0, 0, 0, 0, 16'd0);

    $display("[TB] basic ring");
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("start_T0", 0, 1, 0, 0, 0, 16'd0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(k == 1, 0, 0, 0, 0, 0, 0);
      checkOutput("ring_advance", k, 1, 0, 0, 0, 16'd0);
    end
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("retire_T0_done", 0, 1, 0, 1, 0, 16'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("done_one_cycle", 1, 1, 0, 0, 0, 16'd1);

    $display("[TB] memory wait");
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("at_T5", 5, 1, 0, 0, 0, 16'd1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 1, 0, 1, 0);
      checkOutput("wait_hold_T5", 5, 1, 0, 0, 0, 16'd1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("after_wait_T6", 6, 1, 0, 0, 0, 16'd1);

    $display("[TB] halt");
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("retire2", 0, 1, 0, 1, 0, 16'd2);
    repeat (3) applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("hlt_ignored_before_T3", 3, 1, 0, 0, 0, 16'd2);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("hlt_at_T3", -1, 0, 1, 1, 0, 16'd3);
    applyStimulus(1, 0, 1, 0, 0, 0, 0);
    checkOutput("halt_ignores_start_step", -1, 0, 1, 0, 0, 16'd3);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("halt_reset", -1, 0, 0, 0, 0, 16'd0);

    $display("[TB] single step");
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("step_start_T0", 0, 1, 0, 0, 0, 16'd0);
    repeat (4) applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("step_T4", 4, 1, 0, 0, 0, 16'd0);
    applyStimulus(0, 1, 0, 1, 0, 0, 0);
    checkOutput("pause_entry", -1, 0, 0, 1, 0, 16'd1);
    applyStimulus(1, 1, 0, 1, 0, 1, 0);
    checkOutput("pause_hold", -1, 0, 0, 0, 0, 16'd1);
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    checkOutput("step_resume_T0", 0, 1, 0, 0, 0, 16'd1);
    applyStimulus(0, 1, 0, 1, 0, 0, 0);
    checkOutput("pause_again", -1, 0, 0, 1, 0, 16'd2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("stepmode_drop_resume", 0, 1, 0, 0, 0, 16'd2);

    $display("[TB] watchdog");
    for (int k = 1; k < NUM_T; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("walk_to_T17", k, 1, 0, 0, 0, 16'd2);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("watchdog_fire", 0, 1, 0, 1, 1, 16'd3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("timeout_sticky", 1, 1, 0, 0, 1, 16'd3);

    $display("[TB] counter wrap");
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("wrap_reset", -1, 0, 0, 0, 0, 16'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap_start", 0, 1, 0, 0, 0, 16'd0);
    repeat (65535) applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("count_ffff", 0, 1, 0, 1, 0, 16'hFFFF);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("count_wrap_0", 0, 1, 0, 1, 0, 16'h0000);
    repeat (7) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("at_T7", 7, 1, 0, 0, 0, 16'h0000);
    applyStimulus(0, 0, 0, 1, 0, 0, 1);
    checkOutput("reset_mid_instr", -1, 0, 0, 0, 0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
